// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory-access stage.
package mem_access_pkg;

  localparam int unsigned ADDR_W_DEFAULT   = 15;
  localparam int unsigned MAX_WAIT_DEFAULT = 255;

  // Resolved instruction as handed over by exec; only these fields matter here.
  typedef struct packed {
    logic [5:0] rd;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
  } inst_t;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } mem_state_e;

  // Word accesses only: any low byte-address bit set is an alignment fault.
  function automatic logic addr_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Word-wide data-memory port: request held until ready, single outstanding access.
interface mem_access_if #(
  parameter int unsigned ADDR_W = 15
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_access.sv
// Memory stage: one word load/store per start pulse, writeback values returned with fin.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEFAULT,
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  output logic          fin,
  output logic          err,
  input  inst_t         inst,
  input  logic [31:0]   aluresult,
  input  logic [31:0]   result,
  input  logic [31:0]   rdata1,
  mem_access_if.master  mem,
  output inst_t         inst_out,
  output logic [5:0]    wb_rd,
  output logic          wb_regwrite,
  output logic [31:0]   wb_data
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

  mem_state_e        state_q, state_d;
  inst_t             inst_q, inst_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic              wb_regwrite_q, wb_regwrite_d;
  logic              err_q, err_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  // High address bits beyond the memory window wrap by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^aluresult[31:ADDR_W+2];

  // Next-state, capture and wait-counter logic.
  always_comb begin
    state_d       = state_q;
    inst_d        = inst_q;
    wb_data_d     = wb_data_q;
    wb_regwrite_d = wb_regwrite_q;
    err_d         = err_q;
    req_d         = req_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    cnt_d         = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          inst_d    = inst;
          wb_data_d = result;
          err_d     = 1'b0;
          cnt_d     = '0;
          if (!inst.memread && !inst.memwrite) begin
            state_d       = StDone;
            wb_regwrite_d = inst.regwrite;
          end else if ((inst.memread && inst.memwrite) || addr_misaligned(aluresult)) begin
            state_d       = StDone;
            err_d         = 1'b1;
            wb_regwrite_d = 1'b0;
          end else begin
            state_d = StAccess;
            req_d   = 1'b1;
            we_d    = inst.memwrite;
            addr_d  = aluresult[ADDR_W+1:2];
            wdata_d = rdata1;
          end
        end
      end
      StAccess: begin
        if (mem.mem_ready) begin
          state_d       = StDone;
          req_d         = 1'b0;
          wb_regwrite_d = inst_q.regwrite;
          if (!we_q) wb_data_d = mem.mem_rdata;
        end else begin
          cnt_d = cnt_q + CntW'(1);
          // Last permitted wait cycle expired without a response.
          if (cnt_q == CntW'(MAX_WAIT - 1)) begin
            state_d       = StDone;
            req_d         = 1'b0;
            err_d         = 1'b1;
            wb_regwrite_d = 1'b0;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        err_d   = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and capture registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      inst_q        <= '0;
      wb_data_q     <= '0;
      wb_regwrite_q <= 1'b0;
      err_q         <= 1'b0;
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      inst_q        <= inst_d;
      wb_data_q     <= wb_data_d;
      wb_regwrite_q <= wb_regwrite_d;
      err_q         <= err_d;
      req_q         <= req_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      cnt_q         <= cnt_d;
    end
  end

  assign fin           = (state_q == StDone);
  assign err           = err_q;
  assign inst_out      = inst_q;
  assign wb_rd         = inst_q.rd;
  assign wb_regwrite   = wb_regwrite_q;
  assign wb_data       = wb_data_q;
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with a writeback scoreboard.
module tb_mem_access;
  import mem_access_pkg::*;

  localparam int unsigned AddrW   = 15;
  localparam int unsigned MaxWait = 4;

  typedef struct {
    logic [31:0] data;
    logic        chk_data;
    logic        regwrite;
    logic        err;
    logic [5:0]  rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        fin;
  logic        err;
  inst_t       inst;
  logic [31:0] aluresult;
  logic [31:0] result;
  logic [31:0] rdata1;
  inst_t       inst_out;
  logic [5:0]  wb_rd;
  logic        wb_regwrite;
  logic [31:0] wb_data;

  mem_access_if #(.ADDR_W(AddrW)) mem ();

  mem_access #(.ADDR_W(AddrW), .MAX_WAIT(MaxWait)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .fin         (fin),
    .err         (err),
    .inst        (inst),
    .aluresult   (aluresult),
    .result      (result),
    .rdata1      (rdata1),
    .mem         (mem),
    .inst_out    (inst_out),
    .wb_rd       (wb_rd),
    .wb_regwrite (wb_regwrite),
    .wb_data     (wb_data)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic inst_t mk(input logic [5:0] rd, input logic rw, input logic mr,
                               input logic mw);
    inst_t i;
    i.rd = rd; i.regwrite = rw; i.memread = mr; i.memwrite = mw;
    return i;
  endfunction

  task automatic push(input logic [31:0] d, input logic cd, input logic rw, input logic e,
                      input logic [5:0] rd);
    exp_t x;
    x.data = d; x.chk_data = cd; x.regwrite = rw; x.err = e; x.rd = rd;
    sb.push_back(x);
  endtask

  // One-cycle start pulse; returns just after the edge that sampled it.
  task automatic start(input inst_t i, input logic [31:0] a, input logic [31:0] r,
                       input logic [31:0] d1);
    inst = i; aluresult = a; result = r; rdata1 = d1; enable = 1'b1;
    step();
    enable = 1'b0;
  endtask

  // Waits (bounded) for fin, checks extra wait cycles and pops the scoreboard.
  task automatic wait_fin(input string tag, input int exp_wait);
    int   n = 0;
    exp_t e;
    while (fin !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check({tag, " fin"}, 32'(fin), 32'd1);
    check({tag, " latency"}, 32'(n), 32'(exp_wait));
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard: observed empty expected entry", tag);
    end else begin
      e = sb.pop_front();
      if (e.chk_data) check({tag, " wb_data"}, wb_data, e.data);
      check({tag, " wb_regwrite"}, 32'(wb_regwrite), 32'(e.regwrite));
      check({tag, " err"}, 32'(err), 32'(e.err));
      check({tag, " wb_rd"}, 32'(wb_rd), 32'(e.rd));
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; inst = '0; aluresult = '0; result = '0; rdata1 = '0;
    mem.mem_ready = 1'b0; mem.mem_rdata = '0;
    step(); step();
    rst = 1'b0;
    check("rst fin", 32'(fin), 32'd0);
    check("rst err", 32'(err), 32'd0);
    check("rst mem_req", 32'(mem.mem_req), 32'd0);
    check("rst mem_we", 32'(mem.mem_we), 32'd0);
    check("rst mem_addr", 32'(mem.mem_addr), 32'd0);
    check("rst mem_wdata", mem.mem_wdata, 32'd0);
    check("rst wb_data", wb_data, 32'd0);
    check("rst wb_rd", 32'(wb_rd), 32'd0);
    check("rst wb_regwrite", 32'(wb_regwrite), 32'd0);
    check("rst inst_out", 32'(inst_out), 32'd0);

    // 1: non-memory op forwards result one cycle after enable.
    push(32'h1234_5678, 1'b1, 1'b1, 1'b0, 6'd5);
    start(mk(6'd5, 1'b1, 1'b0, 1'b0), 32'h0, 32'h1234_5678, 32'h0);
    check("t1 mem_req", 32'(mem.mem_req), 32'd0);
    wait_fin("t1", 0);
    // enable coincident with fin must be dropped.
    inst = mk(6'd9, 1'b1, 1'b1, 1'b0); aluresult = 32'h40; enable = 1'b1;
    step();
    enable = 1'b0;
    check("t1 fin pulse", 32'(fin), 32'd0);
    check("t1 en@fin req", 32'(mem.mem_req), 32'd0);
    check("t1 wb_data held", wb_data, 32'h1234_5678);
    step();
    check("t1 en@fin no fin", 32'(fin), 32'd0);

    // 2: load with ready three cycles after request.
    push(32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 6'd7);
    start(mk(6'd7, 1'b1, 1'b1, 1'b0), 32'h0000_0104, 32'h5555_5555, 32'h0);
    check("t2 mem_req", 32'(mem.mem_req), 32'd1);
    check("t2 mem_we", 32'(mem.mem_we), 32'd0);
    check("t2 mem_addr", 32'(mem.mem_addr), 32'h41);
    step(); step();
    check("t2 req held", 32'(mem.mem_req), 32'd1);
    check("t2 fin early", 32'(fin), 32'd0);
    mem.mem_ready = 1'b1; mem.mem_rdata = 32'hDEAD_BEEF;
    step();
    mem.mem_ready = 1'b0; mem.mem_rdata = '0;
    check("t2 req drop", 32'(mem.mem_req), 32'd0);
    wait_fin("t2", 0);
    step();

    // 3: store with zero-wait memory; fin two cycles after enable.
    push(32'h1111_2222, 1'b1, 1'b0, 1'b0, 6'd3);
    mem.mem_ready = 1'b1;
    start(mk(6'd3, 1'b0, 1'b0, 1'b1), 32'h0000_0010, 32'h1111_2222, 32'hCAFE_0001);
    check("t3 mem_req", 32'(mem.mem_req), 32'd1);
    check("t3 mem_we", 32'(mem.mem_we), 32'd1);
    check("t3 mem_addr", 32'(mem.mem_addr), 32'h4);
    check("t3 mem_wdata", mem.mem_wdata, 32'hCAFE_0001);
    check("t3 fin early", 32'(fin), 32'd0);
    step();
    mem.mem_ready = 1'b0;
    wait_fin("t3", 0);
    check("t3 req drop", 32'(mem.mem_req), 32'd0);
    step();

    // 4a: misaligned load faults without touching memory.
    push(32'h0, 1'b0, 1'b0, 1'b1, 6'd4);
    start(mk(6'd4, 1'b1, 1'b1, 1'b0), 32'h0000_0102, 32'h0, 32'h0);
    check("t4a mem_req", 32'(mem.mem_req), 32'd0);
    wait_fin("t4a", 0);
    step();
    check("t4a err pulse", 32'(err), 32'd0);

    // 4b: read and write together is illegal.
    push(32'h0, 1'b0, 1'b0, 1'b1, 6'd6);
    start(mk(6'd6, 1'b1, 1'b1, 1'b1), 32'h0000_0020, 32'h0, 32'h0);
    check("t4b mem_req", 32'(mem.mem_req), 32'd0);
    wait_fin("t4b", 0);
    step();

    // 5: no ready ever; request held MaxWait cycles then aborted.
    push(32'h0, 1'b0, 1'b0, 1'b1, 6'd8);
    start(mk(6'd8, 1'b1, 1'b1, 1'b0), 32'h0000_0040, 32'h0, 32'h0);
    for (int i = 0; i < int'(MaxWait); i++) begin
      check($sformatf("t5 req cyc%0d", i), 32'(mem.mem_req), 32'd1);
      step();
    end
    check("t5 req drop", 32'(mem.mem_req), 32'd0);
    wait_fin("t5", 0);
    step();

    // 6: second enable in ACCESS ignored; reset aborts with no fin.
    start(mk(6'd10, 1'b1, 1'b1, 1'b0), 32'h0000_0080, 32'h0, 32'h0);
    inst = mk(6'd11, 1'b1, 1'b0, 1'b0); aluresult = 32'h0; enable = 1'b1;
    step();
    enable = 1'b0;
    check("t6 ignore en fin", 32'(fin), 32'd0);
    check("t6 ignore en addr", 32'(mem.mem_addr), 32'h20);
    check("t6 ignore en rd", 32'(inst_out.rd), 32'd10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6 rst req", 32'(mem.mem_req), 32'd0);
    check("t6 rst fin", 32'(fin), 32'd0);
    step();
    check("t6 no fin", 32'(fin), 32'd0);
    // Back in IDLE: a plain op completes with one-cycle latency.
    push(32'h0BAD_F00D, 1'b1, 1'b1, 1'b0, 6'd12);
    start(mk(6'd12, 1'b1, 1'b0, 1'b0), 32'h0, 32'h0BAD_F00D, 32'h0);
    wait_fin("t6 idle", 0);
    step();

    check("sb drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
